// File: rtl/adc_pll_reset_sequencer.sv
// Sequences the ADC sampling PLL: resets it, waits for a qualified lock with a
// bounded number of retries, then releases the ADC capture-path reset.
module adc_pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  input  logic       clear_lost,
  output logic       pll_rst,
  output logic       adc_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       retry_nx;
  logic             lock_m, lock_s;
  logic             fail, set_lost;

  // pll_locked comes from the PLL's own domain; two flops before use
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_nx = state;
    retry_nx = retry_cnt;
    fail     = 1'b0;
    set_lost = 1'b0;
    case (state)
      S_RESET_PLL: if (cnt == RST_LAST) state_nx = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s)               state_nx = S_STABLE;
        else if (cnt == TO_LAST)  fail = 1'b1;
      end
      S_STABLE: begin
        if (!lock_s) fail = 1'b1;
        else if (cnt == STB_LAST) begin
          state_nx = S_RUN;
          retry_nx = 2'd0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          set_lost = 1'b1;
          state_nx = S_RESET_PLL;
        end
      end
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_RESET_PLL;
    endcase
    if (fail) begin
      if (retry_cnt < RETRY_MAX) begin
        retry_nx = retry_cnt + 2'd1;
        state_nx = S_RESET_PLL;
      end else begin
        state_nx = S_FAULT;
      end
    end
    // restart overrides every other transition, including a lock-loss event
    if (restart) begin
      state_nx = S_RESET_PLL;
      retry_nx = 2'd0;
      set_lost = 1'b0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= 2'd0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nx;
      retry_cnt <= retry_nx;
      if (restart || state_nx != state)
        cnt <= '0;
      else if (state == S_RESET_PLL || state == S_WAIT_LOCK || state == S_STABLE)
        cnt <= cnt + CNT_W'(1);
      if (set_lost)        lock_lost <= 1'b1;
      else if (clear_lost) lock_lost <= 1'b0;
    end
  end

  assign pll_rst = (state == S_RESET_PLL) || (state == S_FAULT);
  assign adc_rst = (state != S_RUN);
  assign ready   = (state == S_RUN);
  assign fault   = (state == S_FAULT);
  assign state_o = state;

endmodule

// File: tb/tb_adc_pll_reset_sequencer.sv
// Bench for adc_pll_reset_sequencer: directed scenarios plus random lock
// patterns, all compared against a phase/elapsed-time reference model.
module tb_adc_pll_reset_sequencer;
  localparam int RSTC = 4, TO = 20, SC = 8, MAXR = 2;
  localparam logic [9:0] RST_VEC = 10'b11_0_0_0_00_000;

  logic refclk, rst, pll_locked, restart, clear_lost;
  logic pll_rst, adc_rst, ready, fault, lock_lost;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;
  logic [9:0] obs;
  int total = 0, bad = 0;

  adc_pll_reset_sequencer #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC),
                            .MAX_RETRIES(MAXR), .CNT_W(8)) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
    .clear_lost(clear_lost), .pll_rst(pll_rst), .adc_rst(adc_rst), .ready(ready),
    .fault(fault), .lock_lost(lock_lost), .retry_cnt(retry_cnt), .state_o(state_o));

  assign obs = {pll_rst, adc_rst, ready, fault, lock_lost, retry_cnt, state_o};

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model: phase plus the cycle it was entered, lock history as two samples
  int m_phase, m_enter, m_retry, cyc;
  bit m_lost, m_h1, m_h2;

  function automatic void model_reset();
    m_phase = 0; m_retry = 0; m_lost = 0; m_h1 = 0; m_h2 = 0; m_enter = cyc;
  endfunction

  function automatic void model_clock(bit lk, bit rs, bit cl);
    int el = cyc - m_enter;
    int nxt = m_phase;
    bit failed = 0, lost_ev = 0;
    if (rs) begin
      nxt = 0; m_retry = 0;
    end else begin
      if (m_phase == 0 && el == RSTC - 1) nxt = 1;
      if (m_phase == 1) begin
        if (m_h2) nxt = 2;
        else if (el == TO - 1) failed = 1;
      end
      if (m_phase == 2) begin
        if (!m_h2) failed = 1;
        else if (el == SC - 1) begin nxt = 3; m_retry = 0; end
      end
      if (m_phase == 3 && !m_h2) begin lost_ev = 1; nxt = 0; end
      if (failed) begin
        if (m_retry < MAXR) begin m_retry++; nxt = 0; end
        else nxt = 4;
      end
    end
    if (lost_ev) m_lost = 1;
    else if (cl) m_lost = 0;
    if (rs || nxt != m_phase) m_enter = cyc + 1;
    m_phase = nxt;
    m_h2 = m_h1; m_h1 = lk;
    cyc++;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {1'(m_phase == 0 || m_phase == 4), 1'(m_phase != 3), 1'(m_phase == 3),
            1'(m_phase == 4), 1'(m_lost), 2'(m_retry), 3'(m_phase)};
  endfunction

  task automatic step(input bit lk, input bit rs, input bit cl);
    pll_locked = lk; restart = rs; clear_lost = cl;
    @(posedge refclk);
    if (rst) begin cyc++; model_reset(); end
    else model_clock(lk, rs, cl);
    #1;
    restart = 0; clear_lost = 0;
  endtask

  task automatic do_reset();
    rst = 1; #1;
    model_reset();
    step(0, 0, 0); step(0, 0, 0);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; pll_locked = 0; restart = 0; clear_lost = 0; cyc = 0;
    #2; model_reset();
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_vec got=%b want=%b", obs, RST_VEC); end
    step(1, 0, 0); step(1, 0, 0);
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs, exp_vec()); end
    rst = 0;
  endtask

  task automatic test_nominal();
    int prst_cycles = 0, t_stable = -1, t_run = -1;
    do_reset();
    prst_cycles += int'(pll_rst);
    for (int i = 0; i < 40; i++) begin
      step(i >= 10, 0, 0);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL nominal cyc=%0d got=%b want=%b", i, obs, exp_vec()); end
      prst_cycles += int'(pll_rst);
      if (state_o == 3'd2 && t_stable < 0) t_stable = i;
      if (state_o == 3'd3 && t_run < 0) t_run = i;
    end
    total++; if (prst_cycles !== RSTC) begin bad++; $display("FAIL nominal_pll_rst_len got=%0d want=%0d", prst_cycles, RSTC); end
    total++; if (t_run - t_stable !== SC) begin bad++; $display("FAIL nominal_stable_len got=%0d want=%0d", t_run - t_stable, SC); end
    total++; if (obs !== 10'b00_1_0_0_00_011) begin bad++; $display("FAIL nominal_run got=%b want=%b", obs, 10'b0010000011); end
  endtask

  task automatic test_no_lock();
    int wait_cycles = 0;
    do_reset();
    for (int i = 0; i < 3 * (RSTC + TO) + 6; i++) begin
      step(0, 0, 0);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL no_lock cyc=%0d got=%b want=%b", i, obs, exp_vec()); end
      wait_cycles += int'(state_o == 3'd1);
    end
    total++; if (wait_cycles !== 3 * TO) begin bad++; $display("FAIL no_lock_wait_len got=%0d want=%0d", wait_cycles, 3 * TO); end
    total++; if (obs !== 10'b11_0_1_0_10_100) begin bad++; $display("FAIL no_lock_fault got=%b want=%b", obs, 10'b1101010100); end
  endtask

  task automatic test_glitch();
    int max_retry = 0;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step((i >= 4 && i < 9) || i >= 10, 0, 0);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL glitch cyc=%0d got=%b want=%b", i, obs, exp_vec()); end
      if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
    end
    total++; if (max_retry !== 1) begin bad++; $display("FAIL glitch_retry got=%0d want=1", max_retry); end
    total++; if (obs !== 10'b00_1_0_0_00_011) begin bad++; $display("FAIL glitch_run got=%b want=%b", obs, 10'b0010000011); end
  endtask

  task automatic test_loss_run();
    step(0, 0, 0); step(0, 0, 0);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL loss_sync_delay ready got=%b want=1", ready); end
    step(0, 0, 0);
    total++; if (obs !== 10'b11_0_0_1_00_000) begin bad++; $display("FAIL loss_detect got=%b want=%b", obs, 10'b1100100000); end
    for (int i = 0; i < 30; i++) step(1, 0, 0);
    total++; if (obs !== 10'b00_1_0_1_00_011) begin bad++; $display("FAIL loss_sticky got=%b want=%b", obs, 10'b0010100011); end
    step(1, 0, 1);
    total++; if (lock_lost !== 1'b0) begin bad++; $display("FAIL loss_clear got=%b want=0", lock_lost); end
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 1);
    total++; if (lock_lost !== 1'b1 || state_o !== 3'd0) begin bad++; $display("FAIL loss_collision lost=%b state=%0d want lost=1 state=0", lock_lost, state_o); end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL loss_model got=%b want=%b", obs, exp_vec()); end
  endtask

  task automatic test_restart();
    int n = 0;
    do_reset();
    for (int i = 0; i < 3 * (RSTC + TO) + 4; i++) step(0, 0, 0);
    step(0, 1, 0);
    total++; if (obs !== 10'b11_0_0_0_00_000) begin bad++; $display("FAIL restart_fault got=%b want=%b", obs, 10'b1100000000); end
    while (state_o !== 3'd2 && n < 40) begin step(1, 0, 0); n++; end
    total++; if (state_o !== 3'd2) begin bad++; $display("FAIL restart_reach_stable state=%0d want=2", state_o); end
    step(1, 0, 0); step(1, 1, 0);
    total++; if (obs !== 10'b11_0_0_0_00_000) begin bad++; $display("FAIL restart_stable got=%b want=%b", obs, 10'b1100000000); end
    total++; if (obs !== exp_vec()) begin bad++; $display("FAIL restart_model got=%b want=%b", obs, exp_vec()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 0, 0);
    step(1'b1, 0, 1'b0);
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL async_pre state=%0d want=1", state_o); end
    #3 rst = 1;
    #1;
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL async_reset got=%b want=%b", obs, RST_VEC); end
    model_reset();
    step(1, 0, 0);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL async_after cyc=%0d got=%b want=%b", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_random();
    bit lk = 0;
    int shown = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 23) == 0) lk = ~lk;
      if ($urandom_range(0, 599) == 0) do_reset();
      step(lk, $urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        if (shown < 10) begin shown++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs, exp_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_lock();
    test_glitch();
    test_loss_run();
    test_restart();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adc_pll_reset_sequencer.md
Name: adc_pll_reset_sequencer

Overview:
- Supervises the ADC sampling PLL (250 MHz ref in, 250 MHz out, direct mode).
- Drives the PLL reset and waits for lock, with a timeout.
- Qualifies lock as stable before releasing the ADC capture-path reset. On loss of lock it retries a bounded number of times, then parks in FAULT.
- Runs on the free-running PLL reference clock, so it keeps running while the PLL is unlocked. Sits between the board clock input, the PLL instance and the ADC receive logic.

Parameters:
- RST_CYCLES, 16, cycles pll_rst is held high per attempt (min 2)
- LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before the attempt fails
- STABLE_CYCLES, 256, consecutive synchronized-lock cycles required before release
- MAX_RETRIES, 3, failed attempts tolerated before FAULT (total attempts = MAX_RETRIES+1)
- CNT_W, 16, phase counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)

Ports:
- refclk  in  1  sole clock; PLL reference clock
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL locked output; asynchronous to refclk
- restart  in  1  single-cycle pulse; forces a new sequence from any state
- clear_lost  in  1  single-cycle pulse; clears lock_lost
- pll_rst  out  1  reset to the PLL instance
- adc_rst  out  1  active-high reset to ADC capture logic
- ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- lock_lost  out  1  sticky; set when lock drops while in RUN
- retry_cnt  out  2  failed attempts since the last RUN entry or restart
- state_o  out  3  RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4

Behaviour:
- Reset is asynchronous and active-high (rst), on the single clock refclk.
- While rst is high:
  - state = RESET_PLL, counter = 0
  - pll_rst = 1, adc_rst = 1
  - ready = 0, fault = 0, lock_lost = 0, retry_cnt = 0
- Lock synchronizer:
  - pll_locked passes through a 2-flop synchronizer to give lock_s (2-cycle latency).
  - Both synchronizer flops reset to 0.
- Outputs are decoded from registered state only (Moore):
  - pll_rst = (RESET_PLL or FAULT)
  - adc_rst = !(RUN)
  - ready = RUN, fault = FAULT
- The phase counter clears on every state change.
- RESET_PLL: hold for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s = 1: go to STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1: failure.
- STABLE:
  - lock_s = 0 on any cycle: failure.
  - Counter reaches STABLE_CYCLES-1 with lock_s = 1: go to RUN, clear retry_cnt.
- RUN:
  - lock_s = 0: set lock_lost, go to RESET_PLL.
  - retry_cnt is not incremented for this path.
- Failure handling:
  - retry_cnt < MAX_RETRIES: increment retry_cnt, go to RESET_PLL.
  - Otherwise go to FAULT; retry_cnt holds its value.
- FAULT: terminal. pll_rst stays high. Exit only via restart or rst.
- restart:
  - Highest priority in every state, over timeout, lock loss and RUN transitions.
  - Next state = RESET_PLL, counter = 0, retry_cnt = 0. lock_lost is unaffected.
- lock_lost:
  - Cleared by clear_lost.
  - A set and a clear_lost in the same cycle: set wins.
- retry_cnt saturates at MAX_RETRIES; it never wraps.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Nominal start:
  - Stimulus: release rst; pll_locked rises 10 cycles later and stays high.
  - Required: pll_rst high for exactly 4 cycles; state 0→1→2→3; adc_rst falls and ready rises 8 cycles after entering STABLE; retry_cnt = 0.
- No lock:
  - Stimulus: pll_locked held at 0.
  - Required: three RESET_PLL/WAIT_LOCK attempts, each WAIT_LOCK lasting 20 cycles; retry_cnt steps 1, 2; then FAULT with fault = 1, pll_rst = 1, retry_cnt = 2, adc_rst = 1.
- Glitchy lock:
  - Stimulus: pll_locked high 5 cycles, low 1 cycle, then steady high.
  - Required: STABLE aborts; retry_cnt = 1; re-sequence; RUN reached; retry_cnt then reads 0.
- Loss in RUN:
  - Stimulus: in RUN, drop pll_locked.
  - Required: 2 cycles (synchronizer) plus 1 cycle later, adc_rst = 1, ready = 0, lock_lost = 1, state = 0; lock_lost persists after re-lock until a clear_lost pulse.
- Restart and async reset:
  - Stimulus: pulse restart in FAULT, and separately in STABLE; assert rst mid-WAIT_LOCK.
  - Required: restart gives state 0, fault = 0, retry_cnt = 0 next cycle; rst drives all outputs to reset values immediately, with no clock edge.
- Clear/set collision:
  - Stimulus: clear_lost asserted on the same cycle as a RUN lock drop.
  - Required: lock_lost = 1.
